// File: rtl/sof_transmit.sv
// sof_transmit: host-side start-of-frame generator.
// Runs the frame timer, keeps the 11-bit frame number and, on every frame
// boundary, requests the shared send-packet path, issues one SOF write strobe
// and holds the request until the packet has left the send-packet block.
module sof_transmit #(
    parameter int CLKS_PER_FRAME = 48000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SOFEnable,
    input  logic        SOFTxGnt,
    input  logic        sendPacketRdy,
    output logic        SOFTxReq,
    output logic        SOF_SP_WEn,
    output logic [10:0] SOFFrameNum,
    output logic [10:0] frameNum,
    output logic [15:0] SOFTimer,
    output logic        SOFSent,
    output logic        SOFOverrun
);

    typedef enum logic [2:0] {
        SOF_IDLE      = 3'd0,
        SOF_WAIT_GNT  = 3'd1,
        SOF_WAIT_RDY  = 3'd2,
        SOF_WAIT_BUSY = 3'd3,
        SOF_WAIT_DONE = 3'd4
    } sofState_t;

    localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_FRAME - 1);

    sofState_t   state;
    sofState_t   nextState;
    logic        frameTick;
    logic [15:0] nextTimer;
    logic [10:0] nextFrameNum;
    logic [10:0] nextSOFFrameNum;
    logic        nextTxReq;
    logic        nextWEn;
    logic        nextSent;
    logic        nextOverrun;

    // Frame timer and running frame number; disabling parks the timer at 0.
    always_comb begin
        frameTick    = SOFEnable && (SOFTimer == LAST_COUNT);
        nextTimer    = SOFTimer;
        nextFrameNum = frameNum;
        if (!SOFEnable) begin
            nextTimer = 16'd0;
        end else if (frameTick) begin
            nextTimer = 16'd0;
        end else begin
            nextTimer = SOFTimer + 16'd1;
        end
        if (frameTick) begin
            nextFrameNum = frameNum + 11'd1;
        end else begin
            nextFrameNum = frameNum;
        end
    end

    // SOF handshake: next state plus next values of every registered output.
    always_comb begin
        nextState       = state;
        nextTxReq       = SOFTxReq;
        nextSOFFrameNum = SOFFrameNum;
        nextWEn         = 1'b0;
        nextSent        = 1'b0;
        // A boundary while an SOF is still in flight is flagged but not queued.
        nextOverrun     = frameTick && (state != SOF_IDLE);
        case (state)
            SOF_IDLE: begin
                if (frameTick) begin
                    nextState       = SOF_WAIT_GNT;
                    nextTxReq       = 1'b1;
                    nextSOFFrameNum = frameNum + 11'd1;
                end else begin
                    nextState = SOF_IDLE;
                end
            end
            SOF_WAIT_GNT: begin
                if (SOFTxGnt) begin
                    nextState = SOF_WAIT_RDY;
                end else begin
                    nextState = SOF_WAIT_GNT;
                end
            end
            SOF_WAIT_RDY: begin
                if (sendPacketRdy) begin
                    nextState = SOF_WAIT_BUSY;
                    nextWEn   = 1'b1;
                end else begin
                    nextState = SOF_WAIT_RDY;
                end
            end
            SOF_WAIT_BUSY: begin
                // Ready falling shows the send-packet block took the write.
                if (!sendPacketRdy) begin
                    nextState = SOF_WAIT_DONE;
                end else begin
                    nextState = SOF_WAIT_BUSY;
                end
            end
            SOF_WAIT_DONE: begin
                if (sendPacketRdy) begin
                    nextState = SOF_IDLE;
                    nextTxReq = 1'b0;
                    nextSent  = 1'b1;
                end else begin
                    nextState = SOF_WAIT_DONE;
                end
            end
            default: begin
                nextState = SOF_IDLE;
                nextTxReq = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SOF_IDLE;
            SOFTimer    <= 16'd0;
            frameNum    <= 11'd0;
            SOFFrameNum <= 11'd0;
            SOFTxReq    <= 1'b0;
            SOF_SP_WEn  <= 1'b0;
            SOFSent     <= 1'b0;
            SOFOverrun  <= 1'b0;
        end else begin
            state       <= nextState;
            SOFTimer    <= nextTimer;
            frameNum    <= nextFrameNum;
            SOFFrameNum <= nextSOFFrameNum;
            SOFTxReq    <= nextTxReq;
            SOF_SP_WEn  <= nextWEn;
            SOFSent     <= nextSent;
            SOFOverrun  <= nextOverrun;
        end
    end

endmodule

// File: tb/tb_sof_transmit.sv
// tb_sof_transmit: directed and randomized bench for sof_transmit with an
// arbiter stub (sticky grant) and a send-packet stub (busy for busyLen cycles).
module tb_sof_transmit;

    localparam int C = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        SOFEnable;
    logic        SOFTxGnt;
    logic        sendPacketRdy;
    logic        SOFTxReq;
    logic        SOF_SP_WEn;
    logic [10:0] SOFFrameNum;
    logic [10:0] frameNum;
    logic [15:0] SOFTimer;
    logic        SOFSent;
    logic        SOFOverrun;

    sof_transmit #(.CLKS_PER_FRAME(C)) dut (
        .clk(clk), .rst(rst), .SOFEnable(SOFEnable), .SOFTxGnt(SOFTxGnt),
        .sendPacketRdy(sendPacketRdy), .SOFTxReq(SOFTxReq), .SOF_SP_WEn(SOF_SP_WEn),
        .SOFFrameNum(SOFFrameNum), .frameNum(frameNum), .SOFTimer(SOFTimer),
        .SOFSent(SOFSent), .SOFOverrun(SOFOverrun)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // stub state
    bit grantAllow;
    int busyLen;
    int busyCnt;

    // reference model: timer position, frame count and the in-flight SOF
    int mTimer, mFrame, mSofNum;
    bit mActive, mGranted, mWritten, mAccepted;
    bit mWen, mSent, mOvr;

    int wenCount, ovrCount;
    logic [10:0] sentNums[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs sampled at that edge.
    task automatic modelUpdate();
        bit tick;
        if (rst) begin
            mTimer = 0; mFrame = 0; mSofNum = 0;
            mActive = 0; mGranted = 0; mWritten = 0; mAccepted = 0;
            mWen = 0; mSent = 0; mOvr = 0;
        end else begin
            tick = SOFEnable && (mTimer == C - 1);
            mOvr = tick && mActive;
            mWen = 0;
            mSent = 0;
            if (!mActive) begin
                if (tick) begin
                    mActive = 1; mGranted = 0; mWritten = 0; mAccepted = 0;
                    mSofNum = (mFrame + 1) % 2048;
                end
            end else if (!mGranted) begin
                if (SOFTxGnt) mGranted = 1;
            end else if (!mWritten) begin
                if (sendPacketRdy) begin mWritten = 1; mWen = 1; end
            end else if (!mAccepted) begin
                if (!sendPacketRdy) mAccepted = 1;
            end else if (sendPacketRdy) begin
                mActive = 0; mSent = 1;
            end
            mTimer = SOFEnable ? ((mTimer + 1) % C) : 0;
            if (tick) mFrame = (mFrame + 1) % 2048;
        end
    endtask

    // One clock: model, compare every output, then let the stubs react.
    task automatic step();
        @(posedge clk);
        modelUpdate();
        #1;
        chk("timer",       SOFTimer,           16'(mTimer));
        chk("frameNum",    16'(frameNum),      16'(mFrame));
        chk("SOFFrameNum", 16'(SOFFrameNum),   16'(mSofNum));
        chk("SOFTxReq",    16'(SOFTxReq),      16'(mActive));
        chk("SOF_SP_WEn",  16'(SOF_SP_WEn),    16'(mWen));
        chk("SOFSent",     16'(SOFSent),       16'(mSent));
        chk("SOFOverrun",  16'(SOFOverrun),    16'(mOvr));
        if (SOFSent) sentNums.push_back(SOFFrameNum);
        wenCount += int'(SOF_SP_WEn);
        ovrCount += int'(SOFOverrun);
        // arbiter: grant once allowed, hold until the request falls
        SOFTxGnt = SOFTxReq && (SOFTxGnt || grantAllow);
        // send-packet: busy for busyLen cycles after each write
        if (SOF_SP_WEn) begin
            sendPacketRdy = 1'b0;
            busyCnt = busyLen;
        end else if (busyCnt > 0) begin
            busyCnt--;
            if (busyCnt == 0) sendPacketRdy = 1'b1;
        end
        if (SOF_SP_WEn) chk("wen_needs_gnt", 16'(SOFTxGnt), 16'd1);
    endtask

    initial begin
        int n;
        int riseSof;
        int wen0, ovr0, s0;
        bit seen;

        rst = 1'b1; SOFEnable = 1'b0; SOFTxGnt = 1'b0; sendPacketRdy = 1'b1;
        grantAllow = 1'b1; busyLen = 5; busyCnt = 0;
        wenCount = 0; ovrCount = 0;
        mTimer = 0; mFrame = 0; mSofNum = 0;
        mActive = 0; mGranted = 0; mWritten = 0; mAccepted = 0;
        mWen = 0; mSent = 0; mOvr = 0;

        // reset, then 100 disabled cycles
        repeat (3) step();
        rst = 1'b0;
        repeat (100) step();
        chk("idle_timer", SOFTimer, 16'd0);
        chk("idle_frame", 16'(frameNum), 16'd0);
        chk("idle_req", 16'(SOFTxReq), 16'd0);
        chk("idle_wen_count", 16'(wenCount), 16'd0);

        // normal SOFs: first request C cycles after enable, numbers 1,2,3
        sentNums.delete();
        SOFEnable = 1'b1;
        n = 0;
        for (int i = 0; i < 100 && !SOFTxReq; i++) begin step(); n++; end
        chk("req_latency", 16'(n), 16'(C));
        for (int i = 0; i < 200 && sentNums.size() < 3; i++) step();
        chk("sent_count", 16'(sentNums.size()), 16'd3);
        chk("sof_num_1", 16'(sentNums[0]), 16'd1);
        chk("sof_num_2", 16'(sentNums[1]), 16'd2);
        chk("sof_num_3", 16'(sentNums[2]), 16'd3);

        // grant delay: hold grant off 8 cycles after the request rises
        for (int i = 0; i < 100 && SOFTxReq; i++) step();
        grantAllow = 1'b0;
        for (int i = 0; i < 100 && !SOFTxReq; i++) step();
        chk("gd_req_rose", 16'(SOFTxReq), 16'd1);
        wen0 = wenCount;
        repeat (8) step();
        chk("gd_no_wen", 16'(wenCount - wen0), 16'd0);
        grantAllow = 1'b1;
        // grant is driven after the next edge, sampled one edge later, then
        // the write strobe appears on the edge after that: 3 steps in all
        n = 0;
        for (int i = 0; i < 50 && !SOF_SP_WEn; i++) begin step(); n++; end
        chk("gd_wen_delay", 16'(n), 16'd3);

        // overrun: grant held off 30 cycles spans one frame boundary
        for (int i = 0; i < 100 && SOFTxReq; i++) step();
        grantAllow = 1'b0;
        for (int i = 0; i < 100 && !SOFTxReq; i++) step();
        riseSof = int'(SOFFrameNum);
        wen0 = wenCount; ovr0 = ovrCount; s0 = sentNums.size();
        repeat (30) step();
        grantAllow = 1'b1;
        for (int i = 0; i < 100 && sentNums.size() == s0; i++) step();
        chk("ovr_pulses", 16'(ovrCount - ovr0), 16'd1);
        chk("ovr_one_wen", 16'(wenCount - wen0), 16'd1);
        chk("ovr_sof_kept", 16'(sentNums[sentNums.size() - 1]), 16'(riseSof));
        chk("ovr_frame_adv", 16'(frameNum), 16'((riseSof + 1) % 2048));

        // randomized traffic: grant latency, busy length, enable drops
        for (int i = 0; i < 600; i++) begin
            grantAllow = ($urandom_range(0, 3) != 0);
            busyLen = $urandom_range(1, 8);
            if (i % 50 == 0) SOFEnable = ($urandom_range(0, 4) != 0);
            step();
        end

        // frame number wrap 2047 -> 0, SOF carrying 0
        SOFEnable = 1'b1; grantAllow = 1'b1; busyLen = 5;
        for (int i = 0; i < 45000 && frameNum != 11'd2047; i++) step();
        chk("wrap_reached_2047", 16'(frameNum), 16'd2047);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (SOFSent && SOFFrameNum == 11'd0) seen = 1'b1;
        end
        chk("wrap_sof_zero", 16'(seen), 16'd1);

        // reset while waiting for the packet to finish
        for (int i = 0; i < 100 && !(mActive && mAccepted); i++) step();
        chk("rst_in_done", 16'(mActive && mAccepted), 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_req", 16'(SOFTxReq), 16'd0);
        chk("rst_timer", SOFTimer, 16'd0);
        chk("rst_frame", 16'(frameNum), 16'd0);
        chk("rst_sofnum", 16'(SOFFrameNum), 16'd0);
        chk("rst_sent", 16'(SOFSent), 16'd0);
        n = 0;
        for (int i = 0; i < 100 && !SOFTxReq; i++) begin step(); n++; end
        chk("rst_req_latency", 16'(n), 16'(C));
        s0 = sentNums.size();
        for (int i = 0; i < 100 && sentNums.size() == s0; i++) step();
        chk("rst_first_sof", 16'(sentNums[sentNums.size() - 1]), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/sof_transmit.md
# sof_transmit

Host-side start-of-frame generator for the USB host controller. Runs the 1 ms frame timer, maintains the 11-bit frame number, and on each frame boundary requests the shared send-packet path from the send packet arbiter via `SOFTxReq`/`SOFTxGnt`. Once granted, it issues one SOF write strobe to the send-packet block and holds the request until that packet has been fully transmitted. It sits directly upstream of the arbiter's SOF port.

## Interface
- `CLKS_PER_FRAME`, default 48000: clock cycles per frame (48 MHz clock gives 1 ms); legal range 16..65535.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high. Clock is `clk`.
- `SOFEnable`  in  1: level. 1 runs the timer and generates SOFs; 0 holds the timer at 0.
- `SOFTxGnt`  in  1: grant from the send packet arbiter.
- `sendPacketRdy`  in  1: send-packet block idle and able to accept a write.
- `SOFTxReq`  out  1: bus request to the arbiter.
- `SOF_SP_WEn`  out  1: one-cycle write strobe to send-packet (PID SOF is muxed in by the arbiter).
- `SOFFrameNum`  out  11: frame number carried by the SOF in progress; stable from request until release.
- `frameNum`  out  11: running frame number.
- `SOFTimer`  out  16: current position within the frame.
- `SOFSent`  out  1: one-cycle pulse when an SOF completes.
- `SOFOverrun`  out  1: one-cycle pulse when a frame boundary occurs while the previous SOF is still active.

## Operation
- **Timer**
  - While `SOFEnable`=1, `SOFTimer` increments each cycle from 0 to `CLKS_PER_FRAME`-1, then wraps to 0.
  - The wrap cycle is the "frame tick".
  - While `SOFEnable`=0, `SOFTimer` is forced to 0 and no new ticks occur.
  - `frameNum` and `SOFFrameNum` hold their values.
- **Frame number**
  - Each frame tick sets `frameNum` to (`frameNum`+1) mod 2048; 2047 wraps to 0.
  - The SOF issued for that tick carries the new value.
- **State machine** (registered outputs). States: `SOF_IDLE`, `SOF_WAIT_GNT`, `SOF_WAIT_RDY`, `SOF_WAIT_BUSY`, `SOF_WAIT_DONE`.
  - `SOF_IDLE`: on frame tick, go to `SOF_WAIT_GNT` with `SOFTxReq`<=1 and `SOFFrameNum`<=incremented `frameNum`.
  - `SOF_WAIT_GNT`: when `SOFTxGnt`=1, go to `SOF_WAIT_RDY`.
  - `SOF_WAIT_RDY`: when `sendPacketRdy`=1, assert `SOF_SP_WEn` for exactly one cycle and go to `SOF_WAIT_BUSY`.
  - `SOF_WAIT_BUSY`: when `sendPacketRdy`=0 (packet accepted), go to `SOF_WAIT_DONE`.
  - `SOF_WAIT_DONE`: when `sendPacketRdy`=1, set `SOFTxReq`<=0, pulse `SOFSent`, and go to `SOF_IDLE`.
- **Overrun**
  - A frame tick in any state other than `SOF_IDLE` pulses `SOFOverrun` and still increments `frameNum`.
  - No second request is queued, and the active SOF completes with its latched `SOFFrameNum`.
- **Disable mid-operation**
  - Dropping `SOFEnable` does not abort an in-progress SOF; the state machine runs to `SOF_IDLE`.
  - The timer stops immediately.
- **Reset**, from any state: state `SOF_IDLE`, `SOFTimer`=0, `frameNum`=0, `SOFFrameNum`=0, `SOFTxReq`=0, `SOF_SP_WEn`=0, `SOFSent`=0, `SOFOverrun`=0.
- **Handshake rules**
  - `SOFTxReq` never falls before `SOFSent`.
  - `SOF_SP_WEn` is only asserted while `SOFTxGnt`=1.
  - The arbiter drops the grant one cycle after the request falls.

## Timing
- Frame tick at cycle N (the cycle in which `SOFTimer`=`CLKS_PER_FRAME`-1 is sampled): `SOFTxReq`=1, `frameNum` and `SOFFrameNum` updated, and `SOFTimer`=0, all visible at N+1.
- `SOFTxGnt` sampled high at cycle G: state `SOF_WAIT_RDY` at G+1.
- Earliest `SOF_SP_WEn` is G+2 if `sendPacketRdy` is already high.
- `sendPacketRdy` high sampled in `SOF_WAIT_DONE` at cycle D: `SOFTxReq`=0 and `SOFSent`=1 at D+1.
- Period between frame ticks is exactly `CLKS_PER_FRAME` cycles while enabled.
- First tick after enable (or after reset with `SOFEnable`=1) occurs `CLKS_PER_FRAME` cycles after the timer leaves 0.
- No combinational paths from inputs to outputs.

## Test plan
- **Reset and idle:** `CLKS_PER_FRAME`=20, `SOFEnable`=0 for 100 cycles -> `SOFTimer`=0, `SOFTxReq`=0, `frameNum`=0 throughout.
- **Normal SOF:** enable with grant and `sendPacketRdy` modelled by an arbiter/send-packet stub (busy 5 cycles) -> `SOFTxReq` rises 20 cycles after enable, one `SOF_SP_WEn` pulse, `SOFFrameNum`=1, `SOFSent` pulse, request drops; repeats every 20 cycles with `SOFFrameNum` 2, 3, ...
- **Grant delay:** hold `SOFTxGnt`=0 for 8 cycles after the request -> no `SOF_SP_WEn` until 2 cycles after the grant; request held high throughout.
- **Overrun:** hold grant low for 30 cycles -> `SOFOverrun` pulse at the next tick, `frameNum` advances by 2, completed SOF carries `SOFFrameNum`=1, and only one `SOF_SP_WEn` is issued.
- **Frame wrap:** preload by running 2047 frames (or force) -> `frameNum` 2047 -> 0, and SOF carries 0.
- **Reset mid-packet:** assert `rst` in `SOF_WAIT_DONE` -> next cycle all outputs at reset values; a fresh SOF follows after 20 enabled cycles with `SOFFrameNum`=1.
